// File: rtl/wb_seq_if.sv
// wb_seq_if: decode/execute, MDU and register-file signals of the writeback sequencer.
// slave is the sequencer's view; master is the surrounding pipeline's view.
interface wb_seq_if;
  logic        op_valid;
  logic        op_ready;
  logic [2:0]  op_class;
  logic [4:0]  op_rd;
  logic        op_mdu;
  logic        dm_ready;
  logic        mdu_done;
  logic        mdu_start;
  logic        hilo_busy;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [2:0]  rd_sel;
  logic        mem_err;
  logic [31:0] perf_stall_cnt;
  modport slave (
    input  op_valid, op_class, op_rd, op_mdu, dm_ready, mdu_done,
    output op_ready, mdu_start, hilo_busy, rf_we, rf_waddr, rd_sel, mem_err, perf_stall_cnt
  );
  modport master (
    output op_valid, op_class, op_rd, op_mdu, dm_ready, mdu_done,
    input  op_ready, mdu_start, hilo_busy, rf_we, rf_waddr, rd_sel, mem_err, perf_stall_cnt
  );
endinterface

// File: rtl/wb_seq.sv
// wb_seq: writeback sequencer driving the register-file write port, load wait, MDU start and HI/LO hazard.
// Define WB_SEQ_PERF_EN to build the saturating non-IDLE stall counter.
module wb_seq #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 5
) (
  input logic       clk,
  input logic       rst_n,
  wb_seq_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, MEM_WAIT, HILO_WAIT, MDU_WAIT} state_t;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MEM_TIMEOUT - 1);
  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       rd_q, rd_d, waddr_q, waddr_d;
  logic [2:0]       cls_q, cls_d, sel_q, sel_d;
  logic             rf_we_q, rf_we_d, start_q, start_d, busy_q, busy_d, err_q, err_d;
  logic [2:0]       cls;
  logic             accept, blocked, hilo_cls, wr_now, wr_late;
  assign cls      = bus.op_class == 3'b111 ? 3'b000 : bus.op_class;
  assign accept   = bus.op_valid && state_q == IDLE;
  // HI/LO is unusable until the in-flight MDU op signals done
  assign blocked  = busy_q && !bus.mdu_done;
  assign hilo_cls = cls == 3'b011 || cls == 3'b100;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rd_q    <= '0;
      cls_q   <= '0;
      waddr_q <= '0;
      sel_q   <= '0;
      rf_we_q <= 1'b0;
      start_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rd_q    <= rd_d;
      cls_q   <= cls_d;
      waddr_q <= waddr_d;
      sel_q   <= sel_d;
      rf_we_q <= rf_we_d;
      start_q <= start_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (accept) state_d = bus.op_mdu ? (blocked ? MDU_WAIT : IDLE) :
                                       cls == 3'b001 ? MEM_WAIT :
                                       (hilo_cls && blocked) ? HILO_WAIT : IDLE;
      MEM_WAIT:  if (bus.dm_ready || cnt_q == LAST) state_d = IDLE;
      HILO_WAIT: if (bus.mdu_done) state_d = IDLE;
      MDU_WAIT:  if (bus.mdu_done) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end
  always_comb begin
    wr_now  = accept && !bus.op_mdu && cls != 3'b001 && !(hilo_cls && blocked);
    wr_late = (state_q == MEM_WAIT && bus.dm_ready) || (state_q == HILO_WAIT && bus.mdu_done);
    waddr_d = wr_now ? bus.op_rd : wr_late ? rd_q : waddr_q;
    sel_d   = wr_now ? cls : wr_late ? cls_q : sel_q;
    rf_we_d = (wr_now || wr_late) && waddr_d != 5'd0;
    start_d = (accept && bus.op_mdu && !blocked) || (state_q == MDU_WAIT && bus.mdu_done);
    busy_d  = start_d || (busy_q && !bus.mdu_done);
    err_d   = state_q == MEM_WAIT && !bus.dm_ready && cnt_q == LAST;
    cnt_d   = state_q == MEM_WAIT ? cnt_q + 1'b1 : '0;
    rd_d    = accept ? bus.op_rd : rd_q;
    cls_d   = accept ? cls : cls_q;
  end
  assign bus.op_ready  = state_q == IDLE;
  assign bus.rf_we     = rf_we_q;
  assign bus.rf_waddr  = waddr_q;
  assign bus.rd_sel    = sel_q;
  assign bus.mdu_start = start_q;
  assign bus.hilo_busy = busy_q;
  assign bus.mem_err   = err_q;
`ifdef WB_SEQ_PERF_EN
  logic [31:0] perf_q, perf_d;
  assign perf_d = (state_q != IDLE && perf_q != 32'hFFFF_FFFF) ? perf_q + 32'd1 : perf_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perf_q <= '0;
    else perf_q <= perf_d;
  end
  assign bus.perf_stall_cnt = perf_q;
`else
  assign bus.perf_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_wb_seq.sv
// tb_wb_seq: scoreboarded bench for wb_seq; expected pulses are queued by the stimulus and
// matched by a negedge monitor against kind, cycle, address and select.
module tb_wb_seq;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  typedef struct {int kind; int cyc; logic [4:0] addr; logic [2:0] sel;} ev_t;
  ev_t q[$];
  wb_seq_if bus();
  wb_seq dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", n, a, e);
    end
  endtask
  task automatic exp_wr(input int a, input int s);
    q.push_back('{kind: 0, cyc: cyc + 1, addr: 5'(a), sel: 3'(s)});
  endtask
  task automatic exp_ev(input int k);
    q.push_back('{kind: k, cyc: cyc + 1, addr: 5'd0, sel: 3'd0});
  endtask
  task automatic drive(input logic v, input logic m, input int c, input int rd);
    bus.op_valid = v;
    bus.op_mdu   = m;
    bus.op_class = 3'(c);
    bus.op_rd    = 5'(rd);
  endtask
  // kind: 0 write, 1 mem_err, 2 mdu_start
  always @(negedge clk) begin
    int k;
    ev_t e;
    if (rst_n && (bus.rf_we || bus.mem_err || bus.mdu_start)) begin
      k = bus.rf_we ? 0 : bus.mem_err ? 1 : 2;
      tests++;
      if (q.size() == 0) begin
        fails++;
        $display("FAIL unexpected_event kind=%0d cyc=%0d waddr=%0d sel=%0d", k, cyc, bus.rf_waddr, bus.rd_sel);
      end else begin
        e = q.pop_front();
        if (e.kind != k || e.cyc != cyc || (k == 0 && (bus.rf_waddr != e.addr || bus.rd_sel != e.sel))) begin
          fails++;
          $display("FAIL event got kind=%0d cyc=%0d waddr=%0d sel=%0d exp kind=%0d cyc=%0d waddr=%0d sel=%0d",
                   k, cyc, bus.rf_waddr, bus.rd_sel, e.kind, e.cyc, e.addr, e.sel);
        end
      end
    end
  end
  initial begin
    int cls_v[5];
    int sel_v[5];
    cls_v = '{2, 5, 6, 7, 3};
    sel_v = '{2, 5, 6, 0, 3};
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 0, 0);
    bus.dm_ready = 1'b0;
    bus.mdu_done = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_rf_we", 32'(bus.rf_we), 0);
    chk("rst_waddr", 32'(bus.rf_waddr), 0);
    chk("rst_sel", 32'(bus.rd_sel), 0);
    chk("rst_start", 32'(bus.mdu_start), 0);
    chk("rst_busy", 32'(bus.hilo_busy), 0);
    chk("rst_err", 32'(bus.mem_err), 0);
    chk("rst_ready", 32'(bus.op_ready), 1);
    chk("rst_perf", bus.perf_stall_cnt, 0);
    rst_n = 1'b1;
    step();
    // back-to-back ALU writes
    for (int i = 5; i < 8; i++) begin
      drive(1'b1, 1'b0, 0, i);
      exp_wr(i, 0);
      step();
    end
    // remaining single-cycle classes, 111 aliasing to 000, HI read while idle
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, cls_v[i], 12 + i);
      exp_wr(12 + i, sel_v[i]);
      step();
    end
    drive(1'b0, 1'b0, 0, 0);
    step();
    // load with dm_ready three cycles after accept
    drive(1'b1, 1'b0, 1, 8);
    step();
    drive(1'b0, 1'b0, 0, 0);
    chk("ld_ready1", 32'(bus.op_ready), 0);
    step();
    chk("ld_ready2", 32'(bus.op_ready), 0);
    step();
    chk("ld_ready3", 32'(bus.op_ready), 0);
    bus.dm_ready = 1'b1;
    exp_wr(8, 1);
    step();
    bus.dm_ready = 1'b0;
    chk("ld_ready_back", 32'(bus.op_ready), 1);
    step();
    // load timeout
    drive(1'b1, 1'b0, 1, 10);
    step();
    drive(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      chk("to_ready_low", 32'(bus.op_ready), 0);
      if (i == 15) exp_ev(1);
      step();
    end
    chk("to_ready_high", 32'(bus.op_ready), 1);
    chk("to_no_we", 32'(bus.rf_we), 0);
    step();
    // DIV then MFLO waiting on HI/LO
    drive(1'b1, 1'b1, 0, 0);
    exp_ev(2);
    step();
    chk("div_busy", 32'(bus.hilo_busy), 1);
    drive(1'b1, 1'b0, 4, 9);
    step();
    drive(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      chk("hw_busy", 32'(bus.hilo_busy), 1);
      chk("hw_ready", 32'(bus.op_ready), 0);
      step();
    end
    bus.mdu_done = 1'b1;
    exp_wr(9, 4);
    step();
    bus.mdu_done = 1'b0;
    chk("hw_busy_clr", 32'(bus.hilo_busy), 0);
    step();
    // DIV then MULT while busy
    drive(1'b1, 1'b1, 0, 0);
    exp_ev(2);
    step();
    step();
    drive(1'b0, 1'b0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      chk("mw_busy", 32'(bus.hilo_busy), 1);
      step();
    end
    bus.mdu_done = 1'b1;
    exp_ev(2);
    step();
    bus.mdu_done = 1'b0;
    chk("mw_busy_hold1", 32'(bus.hilo_busy), 1);
    step();
    chk("mw_busy_hold2", 32'(bus.hilo_busy), 1);
    drive(1'b1, 1'b0, 3, 0);
    bus.mdu_done = 1'b1;
    step();
    drive(1'b0, 1'b0, 0, 0);
    bus.mdu_done = 1'b0;
    chk("mfhi_r0_we", 32'(bus.rf_we), 0);
    chk("mfhi_r0_sel", 32'(bus.rd_sel), 3);
    chk("mfhi_busy_clr", 32'(bus.hilo_busy), 0);
    step();
    // reset during MEM_WAIT with an MDU op in flight
    drive(1'b1, 1'b1, 0, 0);
    exp_ev(2);
    step();
    drive(1'b1, 1'b0, 1, 20);
    step();
    drive(1'b0, 1'b0, 0, 0);
    step();
`ifdef WB_SEQ_PERF_EN
    chk("perf_total", bus.perf_stall_cnt, 27);
`else
    chk("perf_off", bus.perf_stall_cnt, 0);
`endif
    chk("pre_rst_busy", 32'(bus.hilo_busy), 1);
    chk("pre_rst_sel", 32'(bus.rd_sel), 3);
    rst_n = 1'b0;
    bus.dm_ready = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(bus.hilo_busy), 0);
    chk("mid_rst_sel", 32'(bus.rd_sel), 0);
    chk("mid_rst_we", 32'(bus.rf_we), 0);
    chk("mid_rst_err", 32'(bus.mem_err), 0);
    chk("mid_rst_ready", 32'(bus.op_ready), 1);
    chk("mid_rst_perf", bus.perf_stall_cnt, 0);
    step();
    step();
    rst_n = 1'b1;
    step();
    bus.dm_ready = 1'b0;
    repeat (4) step();
    chk("queue_empty", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
